// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cp0_exc_ctrl
// Description : Exception/interrupt sequencer in front of the CP0 register
//               file. Arbitrates eret/syscall/break/teq requests from decode
//               and latched external IRQs, emits CP0 write strobes, stalls
//               fetch/decode and redirects the PC to the handler or to EPC.
//               Optional feature macro: CP0_TIMER_EN (periodic timer tick
//               folded into the highest-index pending IRQ bit).
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_exc_ctrl #(
  parameter int unsigned IRQ_W        = 5,
  parameter logic [31:0] HANDLER_ADDR = 32'h00400004,
  parameter logic [31:0] TIMER_PERIOD = 32'd100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      status,
  input  logic [31:0]      epc,
  input  logic [31:0]      pc_cur,
  input  logic             syscall_req,
  input  logic             break_req,
  input  logic             teq_req,
  input  logic             eret_req,
  input  logic [IRQ_W-1:0] irq,
  output logic             exc_w,
  output logic             ret_w,
  output logic [4:0]       cause,
  output logic [31:0]      pc_in,
  output logic             stall,
  output logic             redir_valid,
  output logic [31:0]      redir_pc
);

  localparam logic [4:0] c_exc_int = 5'd0;
  localparam logic [4:0] c_exc_sys = 5'd8;
  localparam logic [4:0] c_exc_brk = 5'd9;
  localparam logic [4:0] c_exc_teq = 5'd13;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTER = 2'd1,
    S_RET   = 2'd2,
    S_REDIR = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [IRQ_W-1:0]  r_irq_d;
  logic [IRQ_W-1:0]  r_pend;
  logic [IRQ_W-1:0]  w_edge;
  logic [IRQ_W-1:0]  w_set;
  logic [IRQ_W-1:0]  w_pend_en;
  logic [IRQ_W-1:0]  w_lowest;
  logic [IRQ_W-1:0]  w_clr;

  logic              w_idle;
  logic              w_ie;
  logic              w_take_eret;
  logic              w_take_sys;
  logic              w_take_brk;
  logic              w_take_teq;
  logic              w_take_irq;
  logic              w_take_sync_exc;
  logic              w_take_any;
  logic [4:0]        w_cause_sel;

  logic              r_exc_w;
  logic              r_ret_w;
  logic [4:0]        r_cause;
  logic [31:0]       r_pc_in;
  logic              r_redir_valid;
  logic [31:0]       r_redir_pc;

  // Status bits that this block does not look at.
  logic              w_unused_status;
  assign w_unused_status = ^{status[31:11+IRQ_W], status[7:1]};

  // Request qualification; only evaluated while idle, so anything arriving
  // mid-sequence is dropped and must be re-presented by the stalled decode.
  assign w_idle          = (r_state == S_IDLE);
  assign w_ie            = status[0];
  assign w_take_eret     = w_idle & eret_req;
  assign w_take_sys      = w_idle & syscall_req & w_ie & status[8];
  assign w_take_brk      = w_idle & break_req   & w_ie & status[9];
  assign w_take_teq      = w_idle & teq_req     & w_ie & status[10];
  assign w_pend_en       = r_pend & status[11 +: IRQ_W];
  assign w_take_irq      = w_idle & w_ie & (|w_pend_en);
  assign w_take_sync_exc = w_take_sys | w_take_brk | w_take_teq;
  assign w_take_any      = w_take_eret | w_take_sync_exc | w_take_irq;

  // Isolate the lowest-index enabled pending bit; it is cleared only when the
  // interrupt actually wins arbitration.
  assign w_lowest = w_pend_en & (~w_pend_en + IRQ_W'(1));
  assign w_clr    = (w_take_irq & ~w_take_eret & ~w_take_sync_exc) ? w_lowest : '0;

  assign w_cause_sel = w_take_sys ? c_exc_sys :
                       w_take_brk ? c_exc_brk :
                       w_take_teq ? c_exc_teq : c_exc_int;

  assign w_edge = irq & ~r_irq_d;

`ifdef CP0_TIMER_EN
  logic [31:0] r_timer;
  logic        w_tick;

  assign w_tick = (r_timer == (TIMER_PERIOD - 32'd1));
  assign w_set  = w_edge | (IRQ_W'(w_tick) << (IRQ_W - 1));

  // Free-running timer that wraps after TIMER_PERIOD cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_timer <= '0;
    else        r_timer <= w_tick ? '0 : (r_timer + 32'd1);
  end
`else
  logic w_unused_timer;
  assign w_unused_timer = ^TIMER_PERIOD;
  assign w_set          = w_edge;
`endif

  // IRQ edge detection and pending latch; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_d <= '0;
      r_pend  <= '0;
    end else begin
      r_irq_d <= irq;
      r_pend  <= (r_pend & ~w_clr) | w_set;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: each non-idle state lasts exactly one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_take_eret)     w_next = S_RET;
        else if (w_take_any) w_next = S_ENTER;
      end
      S_ENTER: w_next = S_REDIR;
      S_RET:   w_next = S_REDIR;
      S_REDIR: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Registered strobes and payloads, timed to coincide with the state they
  // belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exc_w       <= 1'b0;
      r_ret_w       <= 1'b0;
      r_cause       <= '0;
      r_pc_in       <= '0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= '0;
    end else begin
      r_exc_w       <= (w_next == S_ENTER);
      r_ret_w       <= (w_next == S_RET);
      r_redir_valid <= (w_next == S_REDIR);
      if (w_idle && (w_next == S_ENTER)) begin
        r_cause <= w_cause_sel;
        r_pc_in <= pc_cur;
      end
      if (r_state == S_ENTER)    r_redir_pc <= HANDLER_ADDR;
      else if (r_state == S_RET) r_redir_pc <= epc;
    end
  end

  assign exc_w       = r_exc_w;
  assign ret_w       = r_ret_w;
  assign cause       = r_cause;
  assign pc_in       = r_pc_in;
  assign redir_valid = r_redir_valid;
  assign redir_pc    = r_redir_pc;
  assign stall       = ~w_idle | w_take_any;

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_exc_ctrl
// Description : Self-checking bench for cp0_exc_ctrl: directed scenarios plus
//               a randomized run against a sequence-step reference model.
//               Honours CP0_TIMER_EN to match the DUT build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_exc_ctrl;

  localparam int          IRQ_W   = 5;
  localparam logic [31:0] HANDLER = 32'h00400004;
  localparam int          PERIOD  = 8;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      status;
  logic [31:0]      epc;
  logic [31:0]      pc_cur;
  logic             syscall_req;
  logic             break_req;
  logic             teq_req;
  logic             eret_req;
  logic [IRQ_W-1:0] irq;
  logic             exc_w;
  logic             ret_w;
  logic [4:0]       cause;
  logic [31:0]      pc_in;
  logic             stall;
  logic             redir_valid;
  logic [31:0]      redir_pc;

  int total = 0;
  int bad   = 0;

  cp0_exc_ctrl #(
    .IRQ_W        (IRQ_W),
    .HANDLER_ADDR (HANDLER),
    .TIMER_PERIOD (32'(PERIOD))
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .status      (status),
    .epc         (epc),
    .pc_cur      (pc_cur),
    .syscall_req (syscall_req),
    .break_req   (break_req),
    .teq_req     (teq_req),
    .eret_req    (eret_req),
    .irq         (irq),
    .exc_w       (exc_w),
    .ret_w       (ret_w),
    .cause       (cause),
    .pc_in       (pc_in),
    .stall       (stall),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc)
  );

  always #5 clk = ~clk;

  // Watchdog: the run is cycle-bounded, this only guards against a hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  // Reset with all inputs quiet; returns at the negedge where rst_n rises.
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    status = '0; epc = '0; pc_cur = '0;
    syscall_req = 1'b0; break_req = 1'b0; teq_req = 1'b0; eret_req = 1'b0;
    irq = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (exc_w !== 1'b0)       begin bad++; $display("FAIL rst_exc_w: got %0b want 0", exc_w); end
    total++; if (ret_w !== 1'b0)       begin bad++; $display("FAIL rst_ret_w: got %0b want 0", ret_w); end
    total++; if (cause !== 5'd0)       begin bad++; $display("FAIL rst_cause: got %0d want 0", cause); end
    total++; if (pc_in !== 32'd0)      begin bad++; $display("FAIL rst_pc_in: got %08h want 0", pc_in); end
    total++; if (stall !== 1'b0)       begin bad++; $display("FAIL rst_stall: got %0b want 0", stall); end
    total++; if (redir_valid !== 1'b0) begin bad++; $display("FAIL rst_redir_valid: got %0b want 0", redir_valid); end
    total++; if (redir_pc !== 32'd0)   begin bad++; $display("FAIL rst_redir_pc: got %08h want 0", redir_pc); end
    // Reset in the middle of an exception entry, with a masked IRQ pending.
    apply_reset();
    status = 32'h0000_0701; pc_cur = 32'h0040_0100;
    irq[1] = 1'b1;
    syscall_req = 1'b1;
    @(negedge clk);
    syscall_req = 1'b0;
    #1;
    total++; if (exc_w !== 1'b1) begin bad++; $display("FAIL midrst_pre_exc_w: got %0b want 1", exc_w); end
    #1;
    rst_n = 1'b0;
    irq = '0;
    #1;
    total++; if (exc_w !== 1'b0)       begin bad++; $display("FAIL midrst_exc_w: got %0b want 0", exc_w); end
    total++; if (stall !== 1'b0)       begin bad++; $display("FAIL midrst_stall: got %0b want 0", stall); end
    total++; if (redir_valid !== 1'b0) begin bad++; $display("FAIL midrst_redir_valid: got %0b want 0", redir_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    status = 32'h0000_1C01;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      total++; if (exc_w !== 1'b0) begin bad++; $display("FAIL midrst_pend_exc_w c%0d: got %0b want 0", c, exc_w); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL midrst_pend_stall c%0d: got %0b want 0", c, stall); end
    end
  endtask

  task automatic test_syscall();
    apply_reset();
    status = 32'h0000_0701; pc_cur = 32'h0040_0100;
    syscall_req = 1'b1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL sys_stall_n: got %0b want 1", stall); end
    @(negedge clk);
    syscall_req = 1'b0; pc_cur = 32'hDEAD_0000;
    #1;
    total++; if (exc_w !== 1'b1)         begin bad++; $display("FAIL sys_exc_w: got %0b want 1", exc_w); end
    total++; if (cause !== 5'd8)         begin bad++; $display("FAIL sys_cause: got %0d want 8", cause); end
    total++; if (pc_in !== 32'h00400100) begin bad++; $display("FAIL sys_pc_in: got %08h want 00400100", pc_in); end
    total++; if (ret_w !== 1'b0)         begin bad++; $display("FAIL sys_ret_w: got %0b want 0", ret_w); end
    total++; if (stall !== 1'b1)         begin bad++; $display("FAIL sys_stall_n1: got %0b want 1", stall); end
    @(negedge clk);
    #1;
    total++; if (redir_valid !== 1'b1) begin bad++; $display("FAIL sys_redir_valid: got %0b want 1", redir_valid); end
    total++; if (redir_pc !== HANDLER) begin bad++; $display("FAIL sys_redir_pc: got %08h want %08h", redir_pc, HANDLER); end
    total++; if (exc_w !== 1'b0)       begin bad++; $display("FAIL sys_exc_w_n2: got %0b want 0", exc_w); end
    total++; if (stall !== 1'b1)       begin bad++; $display("FAIL sys_stall_n2: got %0b want 1", stall); end
    @(negedge clk);
    #1;
    total++; if (redir_valid !== 1'b0) begin bad++; $display("FAIL sys_redir_valid_n3: got %0b want 0", redir_valid); end
    total++; if (stall !== 1'b0)       begin bad++; $display("FAIL sys_stall_n3: got %0b want 0", stall); end
  endtask

  task automatic test_masked();
    apply_reset();
    status = 32'h0000_0601;
    syscall_req = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL masked_stall: got %0b want 0", stall); end
    @(negedge clk);
    syscall_req = 1'b0;
    #1;
    total++; if (exc_w !== 1'b0) begin bad++; $display("FAIL masked_exc_w: got %0b want 0", exc_w); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL masked_stall_n1: got %0b want 0", stall); end
    status = 32'h0000_0701;
    teq_req = 1'b1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL teq_stall: got %0b want 1", stall); end
    @(negedge clk);
    teq_req = 1'b0;
    #1;
    total++; if (exc_w !== 1'b1) begin bad++; $display("FAIL teq_exc_w: got %0b want 1", exc_w); end
    total++; if (cause !== 5'd13) begin bad++; $display("FAIL teq_cause: got %0d want 13", cause); end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_eret();
    apply_reset();
    epc = 32'h0040_0104;
    eret_req = 1'b1;
    @(negedge clk);
    eret_req = 1'b0;
    #1;
    total++; if (ret_w !== 1'b1) begin bad++; $display("FAIL eret_ret_w: got %0b want 1", ret_w); end
    total++; if (exc_w !== 1'b0) begin bad++; $display("FAIL eret_exc_w: got %0b want 0", exc_w); end
    @(negedge clk);
    #1;
    total++; if (redir_valid !== 1'b1)      begin bad++; $display("FAIL eret_redir_valid: got %0b want 1", redir_valid); end
    total++; if (redir_pc !== 32'h00400104) begin bad++; $display("FAIL eret_redir_pc: got %08h want 00400104", redir_pc); end
    total++; if (ret_w !== 1'b0)            begin bad++; $display("FAIL eret_ret_w_n2: got %0b want 0", ret_w); end
    @(negedge clk);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL eret_stall_n3: got %0b want 0", stall); end
    // eret together with an enabled syscall: eret wins
    status = 32'h0000_0701; epc = 32'h0040_0abc;
    eret_req = 1'b1; syscall_req = 1'b1;
    @(negedge clk);
    eret_req = 1'b0; syscall_req = 1'b0;
    #1;
    total++; if (ret_w !== 1'b1) begin bad++; $display("FAIL eretprio_ret_w: got %0b want 1", ret_w); end
    total++; if (exc_w !== 1'b0) begin bad++; $display("FAIL eretprio_exc_w: got %0b want 0", exc_w); end
    @(negedge clk);
    #1;
    total++; if (redir_pc !== 32'h00400abc) begin bad++; $display("FAIL eretprio_redir_pc: got %08h want 00400abc", redir_pc); end
    @(negedge clk);
  endtask

  task automatic test_irq();
    apply_reset();
    status = 32'h0000_1801;
    @(negedge clk);
    irq[0] = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL irq_stall_k: got %0b want 0", stall); end
    @(negedge clk);
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL irq_stall_k1: got %0b want 1", stall); end
    total++; if (exc_w !== 1'b0) begin bad++; $display("FAIL irq_exc_w_k1: got %0b want 0", exc_w); end
    @(negedge clk);
    #1;
    total++; if (exc_w !== 1'b1) begin bad++; $display("FAIL irq_exc_w_k2: got %0b want 1", exc_w); end
    total++; if (cause !== 5'd0) begin bad++; $display("FAIL irq_cause: got %0d want 0", cause); end
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      total++; if ((exc_w | stall) !== 1'b0) begin bad++; $display("FAIL irq_cleared c%0d: got exc_w=%0b stall=%0b want 0", c, exc_w, stall); end
    end
    // irq[1] edge while its enable is clear: held pending, no exception
    status = 32'h0000_0801;
    irq[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      total++; if ((exc_w | stall) !== 1'b0) begin bad++; $display("FAIL irq1_masked c%0d: got exc_w=%0b stall=%0b want 0", c, exc_w, stall); end
    end
    status = 32'h0000_1801;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL irq1_enabled_stall: got %0b want 1", stall); end
    @(negedge clk);
    #1;
    total++; if (exc_w !== 1'b1) begin bad++; $display("FAIL irq1_exc_w: got %0b want 1", exc_w); end
    total++; if (cause !== 5'd0) begin bad++; $display("FAIL irq1_cause: got %0d want 0", cause); end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    status = 32'h0000_0701;
    syscall_req = 1'b1;
    @(negedge clk);
    syscall_req = 1'b0; break_req = 1'b1;
    #1;
    total++; if (exc_w !== 1'b1) begin bad++; $display("FAIL b2b_exc_w: got %0b want 1", exc_w); end
    @(negedge clk);
    break_req = 1'b0;
    #1;
    total++; if (exc_w !== 1'b0)       begin bad++; $display("FAIL b2b_exc_w_n2: got %0b want 0", exc_w); end
    total++; if (redir_valid !== 1'b1) begin bad++; $display("FAIL b2b_redir_valid: got %0b want 1", redir_valid); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      total++; if ((exc_w | stall) !== 1'b0) begin bad++; $display("FAIL b2b_no_queue c%0d: got exc_w=%0b stall=%0b want 0", c, exc_w, stall); end
    end
    // IRQ arriving during eret is taken right after the redirect
    status = 32'h0000_1801; epc = 32'h0040_0200; pc_cur = 32'h0040_0300;
    eret_req = 1'b1;
    @(negedge clk);
    eret_req = 1'b0; irq[0] = 1'b1;
    #1;
    total++; if (ret_w !== 1'b1) begin bad++; $display("FAIL b2b_ret_w: got %0b want 1", ret_w); end
    @(negedge clk);
    #1;
    total++; if (redir_pc !== 32'h00400200) begin bad++; $display("FAIL b2b_redir_pc: got %08h want 00400200", redir_pc); end
    @(negedge clk);
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL b2b_irq_stall: got %0b want 1", stall); end
    @(negedge clk);
    #1;
    total++; if (exc_w !== 1'b1)         begin bad++; $display("FAIL b2b_irq_exc_w: got %0b want 1", exc_w); end
    total++; if (cause !== 5'd0)         begin bad++; $display("FAIL b2b_irq_cause: got %0d want 0", cause); end
    total++; if (pc_in !== 32'h00400300) begin bad++; $display("FAIL b2b_irq_pc_in: got %08h want 00400300", pc_in); end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_timer();
    logic exp_exc;
    apply_reset();
    status = 32'h0000_8001;
    // Cycle c counts from reset release; the counter reads PERIOD-1 in cycle
    // 7 and 15, so entries show at cycles 9 and 17 when the timer is built in.
    for (int c = 0; c < 20; c++) begin
      #1;
`ifdef CP0_TIMER_EN
      exp_exc = (c == 9) || (c == 17);
`else
      exp_exc = 1'b0;
`endif
      total++; if (exc_w !== exp_exc) begin bad++; $display("FAIL timer_exc_w c%0d: got %0b want %0b", c, exc_w, exp_exc); end
      if (exp_exc) begin
        total++; if (cause !== 5'd0) begin bad++; $display("FAIL timer_cause c%0d: got %0d want 0", c, cause); end
      end
      @(negedge clk);
    end
  endtask

  // Reference model tracks the position within a sequence (0 = free,
  // 1 = strobe cycle, 2 = redirect cycle) plus pending bits as plain arrays.
  task automatic test_random();
    logic [IRQ_W-1:0] m_pend, m_prev, en, clr, setv;
    int               m_step, m_timer;
    bit               m_isret, e_exc, e_ret, e_rv;
    bit               ie, tr, ts, tbk, tt, ti, any, tick;
    logic [4:0]       m_cause;
    logic [31:0]      m_pc, m_rpc;
    m_pend = '0; m_prev = '0; m_step = 0; m_timer = 0; m_isret = 1'b0;
    e_exc = 1'b0; e_ret = 1'b0; e_rv = 1'b0; m_cause = '0; m_pc = '0; m_rpc = '0;
    apply_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      total++; if (exc_w !== e_exc)       begin bad++; $display("FAIL rnd_exc_w cyc%0d: got %0b want %0b", cyc, exc_w, e_exc); end
      total++; if (ret_w !== e_ret)       begin bad++; $display("FAIL rnd_ret_w cyc%0d: got %0b want %0b", cyc, ret_w, e_ret); end
      total++; if (redir_valid !== e_rv)  begin bad++; $display("FAIL rnd_redir_valid cyc%0d: got %0b want %0b", cyc, redir_valid, e_rv); end
      if (e_exc) begin
        total++; if (cause !== m_cause) begin bad++; $display("FAIL rnd_cause cyc%0d: got %0d want %0d", cyc, cause, m_cause); end
        total++; if (pc_in !== m_pc)    begin bad++; $display("FAIL rnd_pc_in cyc%0d: got %08h want %08h", cyc, pc_in, m_pc); end
      end
      if (e_rv) begin
        total++; if (redir_pc !== m_rpc) begin bad++; $display("FAIL rnd_redir_pc cyc%0d: got %08h want %08h", cyc, redir_pc, m_rpc); end
      end
      status      = $urandom;
      status[0]   = ($urandom_range(0, 4) != 0);
      syscall_req = ($urandom_range(0, 7) == 0);
      break_req   = ($urandom_range(0, 7) == 0);
      teq_req     = ($urandom_range(0, 7) == 0);
      eret_req    = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < IRQ_W; i++) if ($urandom_range(0, 7) == 0) irq[i] = ~irq[i];
      epc    = $urandom;
      pc_cur = $urandom;
      #1;
      ie  = status[0];
      tr  = eret_req;
      ts  = syscall_req && ie && status[8];
      tbk = break_req && ie && status[9];
      tt  = teq_req && ie && status[10];
      en  = m_pend & status[11 +: IRQ_W];
      ti  = ie && (en != '0);
      any = (m_step == 0) && (tr || ts || tbk || tt || ti);
      total++; if (stall !== ((m_step != 0) || any)) begin bad++; $display("FAIL rnd_stall cyc%0d: got %0b want %0b", cyc, stall, ((m_step != 0) || any)); end
      setv = irq & ~m_prev;
`ifdef CP0_TIMER_EN
      tick = (m_timer == PERIOD - 1);
      if (tick) setv[IRQ_W-1] = 1'b1;
      m_timer = tick ? 0 : m_timer + 1;
`else
      tick = 1'b0;
`endif
      clr = '0; e_exc = 1'b0; e_ret = 1'b0; e_rv = 1'b0;
      if (m_step == 0) begin
        if (any) begin
          m_step = 1;
          if (tr) begin
            e_ret = 1'b1; m_isret = 1'b1;
          end else begin
            e_exc = 1'b1; m_isret = 1'b0; m_pc = pc_cur;
            if (ts)       m_cause = 5'd8;
            else if (tbk) m_cause = 5'd9;
            else if (tt)  m_cause = 5'd13;
            else begin
              m_cause = 5'd0;
              for (int i = IRQ_W - 1; i >= 0; i--) if (en[i]) begin clr = '0; clr[i] = 1'b1; end
            end
          end
        end
      end else if (m_step == 1) begin
        e_rv   = 1'b1;
        m_rpc  = m_isret ? epc : HANDLER;
        m_step = 2;
      end else begin
        m_step = 0;
      end
      m_pend = (m_pend & ~clr) | setv;
      m_prev = irq;
      @(negedge clk);
    end
    syscall_req = 1'b0; break_req = 1'b0; teq_req = 1'b0; eret_req = 1'b0;
    status = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    status = '0; epc = '0; pc_cur = '0;
    syscall_req = 1'b0; break_req = 1'b0; teq_req = 1'b0; eret_req = 1'b0;
    irq = '0;
    test_reset();
    test_syscall();
    test_masked();
    test_eret();
    test_irq();
    test_back_to_back();
    test_timer();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
